tmds_symbol_decoder: RTL and testbench

Receive-side counterpart of the DVI TMDS transmit path. It accepts one 10-bit TMDS word per pixel clock from an external 1:10 deserializer whose word boundary is arbitrary, and finds the symbol boundary by hunting for control tokens. Once locked, it decodes each symbol back into 8-bit pixel data, the two control bits and DE. One instance is used per TMDS channel; on the blue channel, ctrl = {vsync, hsync}.

---
 rtl/tmds_symbol_decoder.sv | 159 +++++++++++++++
 tb/tb_tmds_symbol_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_symbol_decoder.sv
// TMDS receive-side symbol aligner and decoder for one DVI channel.
// Hunts for control tokens across all ten bit offsets, locks, then decodes symbols.
module tmds_symbol_decoder #(
  parameter int LOCK_COUNT = 8,
  parameter int WATCHDOG   = 4096
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic [9:0] in_word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam logic [9:0]  TOK_C0   = 10'b1101010100;
  localparam logic [9:0]  TOK_C1   = 10'b0010101011;
  localparam logic [9:0]  TOK_C2   = 10'b0101010100;
  localparam logic [9:0]  TOK_C3   = 10'b1010101011;
  localparam logic [7:0]  LOCK_MAX = 8'(LOCK_COUNT);
  localparam logic [15:0] WD_LAST  = 16'(WATCHDOG - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [9:0]      w1_p0, w2_p1;
  logic [19:0]     window;
  logic [9:0][9:0] sym;
  logic [9:0][1:0] code;
  logic [9:0]      tok;
  logic [3:0]      kmin;
  logic            any_tok;
  logic [3:0]      cand, cand_nxt, offset_nxt;
  logic [7:0]      run, run_nxt;
  logic [15:0]     wd, wd_nxt;
  logic [7:0]      data_nxt;
  logic [1:0]      ctrl_nxt;
  logic            de_nxt;

  // {hit, code}: hit is set when s is one of the four control tokens.
  function automatic logic [2:0] token_match(input logic [9:0] s);
    logic [2:0] r;
    case (s)
      TOK_C0:  r = 3'b100;
      TOK_C1:  r = 3'b101;
      TOK_C2:  r = 3'b110;
      TOK_C3:  r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] q;
    d    = s[9] ? ~s[7:0] : s[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  // Stage p0/p1: two-word window so that any of the ten offsets yields a full symbol.
  assign window = {w1_p0, w2_p1};

  genvar k;
  for (k = 0; k < 10; k++) begin : g_sym
    logic [2:0] m;
    assign sym[k]  = window[k+9:k];
    assign m       = token_match(sym[k]);
    assign tok[k]  = m[2];
    assign code[k] = m[1:0];
  end

  assign any_tok = |tok;
  assign locked  = (state == LOCKED);

  always_comb begin
    kmin = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (tok[i]) kmin = 4'(i);
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    run_nxt    = run;
    wd_nxt     = wd;
    offset_nxt = offset;
    data_nxt   = 8'd0;
    ctrl_nxt   = 2'b00;
    de_nxt     = 1'b0;
    unique case (state)
      SEARCH: begin
        if (!any_tok) begin
          run_nxt = 8'd0;
        end else if (kmin == cand && run != 8'd0) begin
          run_nxt = (run >= LOCK_MAX) ? LOCK_MAX : run + 8'd1;
          // The token that completes the run is also the first decoded output.
          if (run + 8'd1 == LOCK_MAX) begin
            state_nxt  = LOCKED;
            offset_nxt = cand;
            wd_nxt     = 16'd0;
            ctrl_nxt   = code[kmin];
          end
        end else begin
          cand_nxt = kmin;
          run_nxt  = 8'd1;
        end
      end
      LOCKED: begin
        if (tok[offset]) begin
          wd_nxt   = 16'd0;
          ctrl_nxt = code[offset];
        end else if (wd == WD_LAST) begin
          state_nxt = SEARCH;
          run_nxt   = 8'd0;
          wd_nxt    = wd + 16'd1;
        end else begin
          wd_nxt   = wd + 16'd1;
          de_nxt   = 1'b1;
          data_nxt = tmds_decode(sym[offset]);
          ctrl_nxt = ctrl;
        end
      end
    endcase
  end

  // Stage p2: registered decode outputs, two edges after in_word is sampled.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      w1_p0  <= 10'd0;
      w2_p1  <= 10'd0;
      state  <= SEARCH;
      cand   <= 4'd0;
      run    <= 8'd0;
      wd     <= 16'd0;
      offset <= 4'd0;
      data   <= 8'd0;
      ctrl   <= 2'b00;
      de     <= 1'b0;
    end else begin
      w1_p0  <= in_word;
      w2_p1  <= w1_p0;
      state  <= state_nxt;
      cand   <= cand_nxt;
      run    <= run_nxt;
      wd     <= wd_nxt;
      offset <= offset_nxt;
      data   <= data_nxt;
      ctrl   <= ctrl_nxt;
      de     <= de_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// Bench for tmds_symbol_decoder: serial-stream stimulus from a TMDS encoder model,
// with expectations from token hunting rules and an encoder-derived decode table.
module tb_tmds_symbol_decoder;

  localparam int LC = 8;
  localparam int WD = 16;

  logic       pixclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [9:0] in_word = 10'd0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  tmds_symbol_decoder #(.LOCK_COUNT(LC), .WATCHDOG(WD)) dut (
    .pixclk (pixclk),
    .rst_n  (rst_n),
    .in_word(in_word),
    .data   (data),
    .ctrl   (ctrl),
    .de     (de),
    .locked (locked),
    .offset (offset)
  );

  always #5 pixclk = ~pixclk;

  int total = 0;
  int bad   = 0;

  bit   bits[$];
  int   dec_tab[1024];
  int   enc_cnt;
  logic lk_h[$];
  logic de_h[$];
  logic [7:0] dt_h[$];

  // model of the receiver, expressed over the serial window
  bit         m_lk;
  int         m_off, m_cand, m_run, m_wd;
  logic [9:0] m_w1, m_w2;
  int         e_data, e_ctrl, e_de;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] tok_of(input int c);
    case (c)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic int tok_code(input logic [9:0] s);
    for (int c = 0; c < 4; c++) if (s == tok_of(c)) return c;
    return -1;
  endfunction

  // DVI transition-minimising stage, then optional inversion with q[9] = inv
  function automatic logic [9:0] enc_forced(input logic [7:0] d, input bit inv);
    logic [8:0] qm;
    int n1;
    bit use_xnor;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  task automatic push_sym(input logic [9:0] q);
    for (int i = 0; i < 10; i++) bits.push_back(q[i]);
  endtask

  task automatic send_tok(input int c);
    push_sym(tok_of(c));
    enc_cnt = 0;
  endtask

  // running-disparity encoder: enc_cnt tracks ones minus zeros sent so far
  task automatic send_byte(input logic [7:0] d);
    logic [9:0] q0, q;
    int n1, n0;
    bit inv;
    q0 = enc_forced(d, 1'b0);
    n1 = $countones(q0[7:0]);
    n0 = 8 - n1;
    if (enc_cnt == 0 || n1 == n0) inv = ~q0[8];
    else inv = (enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1);
    q = enc_forced(d, inv);
    push_sym(q);
    enc_cnt += 2 * $countones(q) - 10;
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) bits.push_back(1'($urandom));
  endtask

  task automatic model_step();
    logic [19:0] win;
    logic [9:0]  s;
    int kmin, c;
    win  = {m_w1, m_w2};
    kmin = -1;
    for (int k = 9; k >= 0; k--) if (tok_code(win[k +: 10]) >= 0) kmin = k;
    if (!m_lk) begin
      e_de = 0; e_data = 0; e_ctrl = 0;
      if (kmin < 0) m_run = 0;
      else if (kmin == m_cand && m_run > 0) begin
        m_run++;
        if (m_run == LC) begin
          m_lk = 1; m_off = m_cand; m_wd = 0;
          e_ctrl = tok_code(win[m_off +: 10]);
        end
      end else begin
        m_cand = kmin; m_run = 1;
      end
    end else begin
      s = win[m_off +: 10];
      c = tok_code(s);
      if (c >= 0) begin
        m_wd = 0; e_de = 0; e_data = 0; e_ctrl = c;
      end else if (m_wd == WD - 1) begin
        m_lk = 0; m_run = 0; e_de = 0; e_data = 0; e_ctrl = 0;
      end else begin
        m_wd++; e_de = 1; e_data = dec_tab[s];
      end
    end
  endtask

  task automatic cycle();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = bits.pop_front();
    in_word = w;
    model_step();
    m_w2 = m_w1;
    m_w1 = w;
    @(posedge pixclk);
    #1;
    chk("locked", 16'(locked), 16'(m_lk));
    chk("de", 16'(de), 16'(e_de));
    chk("offset", 16'(offset), 16'(m_off));
    chk("ctrl", 16'(ctrl), 16'(e_ctrl));
    if (e_data >= 0) chk("data", 16'(data), 16'(e_data));
    lk_h.push_back(locked);
    de_h.push_back(de);
    dt_h.push_back(data);
  endtask

  task automatic drain();
    while (bits.size() >= 10) cycle();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    in_word = 10'($urandom);
    repeat (2) @(posedge pixclk);
    #1;
    chk("rst_data", 16'(data), 16'd0);
    chk("rst_ctrl", 16'(ctrl), 16'd0);
    chk("rst_de", 16'(de), 16'd0);
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_offset", 16'(offset), 16'd0);
    bits.delete(); lk_h.delete(); de_h.delete(); dt_h.delete();
    m_lk = 0; m_off = 0; m_cand = 0; m_run = 0; m_wd = 0;
    m_w1 = 10'd0; m_w2 = 10'd0;
    e_data = 0; e_ctrl = 0; e_de = 0;
    enc_cnt = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    automatic logic [7:0] corner[5] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h10};
    for (int i = 0; i < 1024; i++) dec_tab[i] = -1;
    for (int b = 0; b < 256; b++) begin
      dec_tab[enc_forced(8'(b), 1'b0)] = b;
      dec_tab[enc_forced(8'(b), 1'b1)] = b;
    end

    // lock threshold: 7 tokens, a data symbol, then 8 tokens
    do_reset();
    for (int i = 0; i < 7; i++) send_tok(0);
    send_byte(8'h3C);
    for (int i = 0; i < 12; i++) send_tok(0);
    drain();
    for (int i = 0; i <= LC; i++) chk("no_early_lock", 16'(lk_h[i]), 16'd0);
    chk("thr_after_data", 16'(lk_h[9]), 16'd0);
    chk("thr_7th_of_run2", 16'(lk_h[16]), 16'd0);
    chk("thr_8th_of_run2", 16'(lk_h[17]), 16'd1);
    chk("thr_lock_de", 16'(de_h[17]), 16'd0);

    // watchdog: token on the expiring cycle keeps lock, 16 data-only cycles drop it
    do_reset();
    for (int i = 0; i < 12; i++) send_tok(1);
    for (int i = 0; i < 15; i++) send_byte(8'($urandom));
    send_tok(1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    for (int i = 0; i < 4; i++) send_tok(1);
    drain();
    chk("wd_15th_data", 16'(lk_h[28]), 16'd1);
    chk("wd_saved_by_token", 16'(lk_h[29]), 16'd1);
    chk("wd_15th_again", 16'(lk_h[44]), 16'd1);
    chk("wd_16th_drop", 16'(lk_h[45]), 16'd0);
    chk("wd_16th_de", 16'(de_h[45]), 16'd0);

    // decode corners with both q[9] polarities
    do_reset();
    for (int i = 0; i < 10; i++) send_tok(2);
    for (int j = 0; j < 10; j++) push_sym(enc_forced(corner[j/2], 1'(j % 2)));
    for (int i = 0; i < 4; i++) send_tok(2);
    drain();
    for (int j = 0; j < 10; j++) begin
      chk("corner_data", 16'(dt_h[j+12]), 16'(corner[j/2]));
      chk("corner_de", 16'(de_h[j+12]), 16'd1);
    end

    // alignment sweep over every bit rotation
    for (int r = 0; r < 10; r++) begin
      do_reset();
      push_rand_bits(r);
      for (int line = 0; line < 4; line++) begin
        automatic int c = int'($urandom_range(0, 3));
        for (int i = 0; i < 16; i++) send_tok(c);
        for (int i = 0; i < 12; i++) send_byte(8'($urandom));
      end
      for (int i = 0; i < 16; i++) send_tok(3);
      drain();
      chk("sweep_locked", 16'(locked), 16'd1);
      chk("sweep_offset", 16'(offset), 16'(r));
      if (r == 3) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", 16'(locked), 16'd0);
        chk("async_rst_offset", 16'(offset), 16'd0);
        chk("async_rst_de", 16'(de), 16'd0);
      end
    end

    // 3-bit slip after lock at offset 8 must relock at offset 1
    do_reset();
    push_rand_bits(8);
    for (int i = 0; i < 16; i++) send_tok(0);
    for (int i = 0; i < 12; i++) send_byte(8'($urandom));
    for (int i = 0; i < 16; i++) send_tok(1);
    push_rand_bits(3);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    for (int i = 0; i < 40; i++) send_tok(2);
    for (int i = 0; i < 12; i++) send_byte(8'($urandom));
    for (int i = 0; i < 6; i++) send_tok(0);
    drain();
    chk("slip_locked", 16'(locked), 16'd1);
    chk("slip_offset", 16'(offset), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
